// File: rtl/fp_add_pkg.sv
// Shared types and constants for the shared FP adder arbiter.
package fp_add_pkg;

  localparam int FP_W        = 32;
  localparam int ADD_LATENCY = 4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } arb_state_e;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester-side bundle: operand handshake in, one-hot result return out.
interface fp_add_arbiter_if
  import fp_add_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 4
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*FP_W-1:0]  req_a;
  logic [N_REQ*FP_W-1:0]  req_b;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic [N_REQ-1:0]       rsp_valid;
  logic [FP_W-1:0]        rsp_result;
  logic [TAG_W-1:0]       rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_tag,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_tag,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin grant: lowest requester at or after the pointer wins; pointer
// moves past the winner on every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_idx;
  logic [N-1:0]    w_gnt;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_found;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned (no latch); blocking '=' is correct here because later
  // iterations must see w_found from earlier ones.
  always_comb begin
    w_gnt    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int off = 0; off < N; off++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(off);
      if (w_idx >= (ID_W+1)'(N)) w_idx = w_idx - (ID_W+1)'(N);
      if (!w_found && en && req[w_idx[ID_W-1:0]]) begin
        w_found                  = 1'b1;
        w_gnt[w_idx[ID_W-1:0]]   = 1'b1;
        w_gnt_id                 = w_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_id == ID_W'(N-1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  assign gnt    = w_gnt;
  assign gnt_id = w_gnt_id;

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency FP adder among N_REQ requesters, tracks each issue
// through a shadow pipe and can drain the adder. Optional FP_ADD_ARB_STATS_EN.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = ADD_LATENCY,
  parameter int TAG_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_add_arbiter_if.slave       bus,
  output fp32_t                 add_a,
  output fp32_t                 add_b,
  input  fp32_t                 add_result,
  input  logic                  drain_req,
  output logic                  idle
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]   stat_grants,
  output logic [31:0]           stat_bubbles
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LATENCY + 1);

  arb_state_e       r_state;
  logic             r_idle;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] w_inflight_nxt;
  logic             w_arb_en;
  logic             w_issue;
  logic             w_retire;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic [TAG_W-1:0] w_tag;

  logic             r_sv   [LATENCY];
  logic [ID_W-1:0]  r_sid  [LATENCY];
  logic [TAG_W-1:0] r_stag [LATENCY];

  // Reset is folded in so nothing is granted while the adder is being cleared.
  assign w_arb_en = (r_state == RUN) && !drain_req && !reset;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req_valid),
    .en     (w_arb_en),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign bus.req_ready = w_gnt;
  assign w_issue       = |w_gnt;

  always_comb begin
    add_a = '0;
    add_b = '0;
    w_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        add_a = bus.req_a[i*FP_W +: FP_W];
        add_b = bus.req_b[i*FP_W +: FP_W];
        w_tag = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // NOTE: the whole shadow pipe is reset, not only the valids, so rsp_tag
  // reads 0 after reset instead of a stale tag from a dropped transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_sv[i]   <= 1'b0;
        r_sid[i]  <= '0;
        r_stag[i] <= '0;
      end
    end else begin
      r_sv[0]   <= w_issue;
      r_sid[0]  <= w_gnt_id;
      r_stag[0] <= w_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_sv[i]   <= r_sv[i-1];
        r_sid[i]  <= r_sid[i-1];
        r_stag[i] <= r_stag[i-1];
      end
    end
  end

  assign w_retire = r_sv[LATENCY-1];

  always_comb begin
    bus.rsp_valid = '0;
    if (w_retire && !reset) bus.rsp_valid[r_sid[LATENCY-1]] = 1'b1;
  end

  assign bus.rsp_result = add_result;
  assign bus.rsp_tag    = r_stag[LATENCY-1];

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_issue && !w_retire)      w_inflight_nxt = r_inflight + CNT_W'(1);
    else if (!w_issue && w_retire) w_inflight_nxt = r_inflight - CNT_W'(1);
  end

  // HALTED is entered on the edge that retires the last op, so idle rises
  // the cycle after that final response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_idle     <= 1'b0;
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      case (r_state)
        RUN: begin
          if (drain_req) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!drain_req) begin
            r_state <= RUN;
          end else if (w_inflight_nxt == '0) begin
            r_state <= HALTED;
            r_idle  <= 1'b1;
          end
        end
        HALTED: begin
          if (!drain_req) begin
            r_state <= RUN;
            r_idle  <= 1'b0;
          end
        end
        default: begin
          r_state <= RUN;
          r_idle  <= 1'b0;
        end
      endcase
    end
  end

  assign idle = r_idle;

`ifdef FP_ADD_ARB_STATS_EN
  logic [31:0] r_stat_grants [N_REQ];
  logic [31:0] r_stat_bubbles;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) r_stat_grants[i] <= '0;
      r_stat_bubbles <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_gnt[i]) r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
      end
      if (r_state == RUN && !w_issue) r_stat_bubbles <= r_stat_bubbles + 32'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) stat_grants[i*32 +: 32] = r_stat_grants[i];
  end

  assign stat_bubbles = r_stat_bubbles;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural 4-stage FP adder beside it.
module tb_fp_add_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int TW  = 4;

  localparam logic [31:0] F_HALF = 32'h3F000000;
  localparam logic [31:0] F_1    = 32'h3F800000;
  localparam logic [31:0] F_1P5  = 32'h3FC00000;
  localparam logic [31:0] F_2    = 32'h40000000;
  localparam logic [31:0] F_3    = 32'h40400000;
  localparam logic [31:0] F_4    = 32'h40800000;
  localparam logic [31:0] F_5    = 32'h40A00000;
  localparam logic [31:0] F_6    = 32'h40C00000;
  localparam logic [31:0] F_7    = 32'h40E00000;
  localparam logic [31:0] F_8    = 32'h41000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drain_req = 1'b0;
  logic        idle;
  logic [31:0] add_a, add_b, add_result;
`ifdef FP_ADD_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_bubbles;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          q_cyc [$];
  logic [N-1:0] q_vec [$];
  logic [TW-1:0] q_tag [$];
  logic [31:0] q_res [$];

  fp_add_arbiter_if #(.N_REQ(N), .TAG_W(TW)) bus ();

  fp_add_arbiter #(.N_REQ(N), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .drain_req  (drain_req),
    .idle       (idle)
`ifdef FP_ADD_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_bubbles (stat_bubbles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: normal numbers only, exact for the small values used.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    int e;
    if (x[30:0] == 31'd0) return 0.0;
    e = int'(x[30:23]) - 127 + 1023;
    d = {x[31], e[10:0], x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [31:0] ad_pipe [LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) ad_pipe[i] <= 32'd0;
    end else begin
      ad_pipe[0] <= r2sp(sp2r(add_a) + sp2r(add_b));
      for (int i = 1; i < LAT; i++) ad_pipe[i] <= ad_pipe[i-1];
    end
  end
  assign add_result = ad_pipe[LAT-1];

  always @(negedge clk) begin
    if (|bus.rsp_valid) begin
      q_cyc.push_back(cyc);
      q_vec.push_back(bus.rsp_valid);
      q_tag.push_back(bus.rsp_tag);
      q_res.push_back(bus.rsp_result);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] t);
    bus.req_valid[i]         = v;
    bus.req_a[i*32 +: 32]    = a;
    bus.req_b[i*32 +: 32]    = b;
    bus.req_tag[i*TW +: TW]  = t;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
  endtask

  task automatic clear_log();
    q_cyc.delete();
    q_vec.delete();
    q_tag.delete();
    q_res.delete();
  endtask

  task automatic apply_reset();
    clear_reqs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    step();
    step();
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", bus.req_ready); end
    total++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_tag !== 4'h0 || bus.rsp_result !== 32'd0) begin
      bad++;
      $display("FAIL rst_rsp got v=%b tag=%h res=%h want 0/0/0", bus.rsp_valid, bus.rsp_tag, bus.rsp_result);
    end
    total++;
    if (idle !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0) begin
      bad++;
      $display("FAIL rst_out got idle=%b a=%h b=%h want 0/0/0", idle, add_a, add_b);
    end
    clear_reqs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    int hs;
    clear_log();
    drive(0, 1'b1, F_1, F_1, 4'h5);
    @(negedge clk);
    hs = cyc;
    total++;
    if (bus.req_ready !== 4'b0001 || add_a !== F_1 || add_b !== F_1) begin
      bad++;
      $display("FAIL single_issue got rdy=%b a=%h b=%h want 0001/%h/%h", bus.req_ready, add_a, add_b, F_1, F_1);
    end
    step();
    clear_reqs();
    @(negedge clk);
    total++;
    if (add_a !== 32'd0) begin bad++; $display("FAIL single_bubble got a=%h want 0", add_a); end
    repeat (LAT + 3) step();
    total++;
    if (q_cyc.size() != 1) begin
      bad++;
      $display("FAIL single_count got=%0d want=1", q_cyc.size());
    end else begin
      total++;
      if (q_cyc[0] !== hs + 4 || q_vec[0] !== 4'b0001 || q_tag[0] !== 4'h5 || q_res[0] !== F_2) begin
        bad++;
        $display("FAIL single_rsp got cyc=%0d v=%b tag=%h res=%h want %0d/0001/5/%h",
                 q_cyc[0], q_vec[0], q_tag[0], q_res[0], hs + 4, F_2);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [TW-1:0] exp_tag [5] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h8};
    logic [31:0]   exp_res [5] = '{F_2, F_3, F_4, F_2, F_2};
    int hs0 = 0;
    apply_reset();
    clear_log();
    drive(0, 1'b1, F_1,   F_1,    4'h8);
    drive(1, 1'b1, F_1,   F_2,    4'h9);
    drive(2, 1'b1, F_2,   F_2,    4'hA);
    drive(3, 1'b1, F_1P5, F_HALF, 4'hB);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) hs0 = cyc;
      total++;
      if (bus.req_ready !== exp_gnt[k]) begin
        bad++;
        $display("FAIL rr_gnt%0d got=%b want=%b", k, bus.req_ready, exp_gnt[k]);
      end
      step();
    end
    clear_reqs();
    repeat (LAT + 2) step();
    total++;
    if (q_cyc.size() != 5) begin bad++; $display("FAIL rr_count got=%0d want=5", q_cyc.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < q_cyc.size()) begin
        total++;
        if (q_cyc[k] !== hs0 + 4 + k || q_vec[k] !== exp_gnt[k] || q_tag[k] !== exp_tag[k] ||
            q_res[k] !== exp_res[k]) begin
          bad++;
          $display("FAIL rr_rsp%0d got cyc=%0d v=%b tag=%h res=%h want %0d/%b/%h/%h", k,
                   q_cyc[k], q_vec[k], q_tag[k], q_res[k], hs0 + 4 + k, exp_gnt[k], exp_tag[k], exp_res[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [8] = '{F_1, F_1, F_2, F_1, F_2, F_3, F_4, F_HALF};
    logic [31:0] b_tab [8] = '{F_1, F_2, F_2, F_4, F_4, F_4, F_4, F_1P5};
    logic [31:0] r_tab [8] = '{F_2, F_3, F_4, F_5, F_6, F_7, F_8, F_2};
    int hs0 = 0;
    clear_log();
    for (int k = 0; k < 8; k++) begin
      drive(1, 1'b1, a_tab[k], b_tab[k], 4'(k));
      @(negedge clk);
      if (k == 0) hs0 = cyc;
      total++;
      if (bus.req_ready !== 4'b0010) begin
        bad++;
        $display("FAIL b2b_gnt%0d got=%b want=0010", k, bus.req_ready);
      end
      step();
    end
    clear_reqs();
    repeat (LAT + 2) step();
    total++;
    if (q_cyc.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", q_cyc.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < q_cyc.size()) begin
        total++;
        if (q_cyc[k] !== hs0 + 4 + k || q_vec[k] !== 4'b0010 || q_tag[k] !== 4'(k) || q_res[k] !== r_tab[k]) begin
          bad++;
          $display("FAIL b2b_rsp%0d got cyc=%0d v=%b tag=%h res=%h want %0d/0010/%h/%h", k,
                   q_cyc[k], q_vec[k], q_tag[k], q_res[k], hs0 + 4 + k, 4'(k), r_tab[k]);
        end
      end
    end
  endtask

  task automatic test_drain();
    int c = 0;
    clear_log();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, F_1, F_1, 4'(k + 1));
      @(negedge clk);
      if (k == 0) c = cyc;
      total++;
      if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL drain_issue%0d got=%b want=0001", k, bus.req_ready); end
      step();
    end
    drain_req = 1'b1;
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL drain_gnt_c%0d got=%b want=0000", k, bus.req_ready); end
      total++;
      if (idle !== (k >= 7)) begin bad++; $display("FAIL drain_idle_c%0d got=%b want=%b", k, idle, (k >= 7)); end
      step();
    end
    total++;
    if (q_cyc.size() != 3) begin bad++; $display("FAIL drain_count got=%0d want=3", q_cyc.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < q_cyc.size()) begin
        total++;
        if (q_cyc[k] !== c + 4 + k || q_vec[k] !== 4'b0001 || q_tag[k] !== 4'(k + 1) || q_res[k] !== F_2) begin
          bad++;
          $display("FAIL drain_rsp%0d got cyc=%0d v=%b tag=%h res=%h want %0d/0001/%h/%h", k,
                   q_cyc[k], q_vec[k], q_tag[k], q_res[k], c + 4 + k, 4'(k + 1), F_2);
        end
      end
    end
    drain_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0000 || idle !== 1'b1) begin
      bad++;
      $display("FAIL drain_release got rdy=%b idle=%b want 0000/1", bus.req_ready, idle);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001 || idle !== 1'b0) begin
      bad++;
      $display("FAIL drain_resume got rdy=%b idle=%b want 0001/0", bus.req_ready, idle);
    end
    step();
    clear_reqs();
    repeat (LAT + 2) step();
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, F_1, F_2, 4'h3);
    repeat (2) step();
    clear_reqs();
    bus.req_valid[3] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_gate got rdy=%b rsp=%b want 0000/0000", bus.req_ready, bus.rsp_valid);
    end
    step();
    reset = 1'b0;
    clear_reqs();
    clear_log();
    repeat (LAT + 3) step();
    total++;
    if (q_cyc.size() != 0) begin bad++; $display("FAIL midrst_dropped got=%0d rsp want=0", q_cyc.size()); end
    bus.req_valid = 4'b1111;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001 || idle !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ptr got rdy=%b idle=%b want 0001/0", bus.req_ready, idle);
    end
    step();
    clear_reqs();
    repeat (LAT + 2) step();
  endtask

`ifdef FP_ADD_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      drive(2, 1'b1, F_1, F_1, 4'(k));
      step();
    end
    clear_reqs();
    repeat (3) step();
    @(negedge clk);
    total++;
    if (stat_grants[2*32 +: 32] !== 32'd6) begin
      bad++;
      $display("FAIL stat_grants2 got=%0d want=6", stat_grants[2*32 +: 32]);
    end
    total++;
    if (stat_grants[0 +: 32] !== 32'd0) begin
      bad++;
      $display("FAIL stat_grants0 got=%0d want=0", stat_grants[0 +: 32]);
    end
    total++;
    if (stat_bubbles !== 32'd3) begin bad++; $display("FAIL stat_bubbles got=%0d want=3", stat_bubbles); end
    step();
    repeat (LAT + 2) step();
  endtask
`endif

  initial begin
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_drain();
    test_reset_mid();
`ifdef FP_ADD_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
